fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the controller/datapath: keeps the fetch PC,
//  reads a variable-latency instruction memory over a req/ack handshake, and buffers words in
//  a DEPTH-entry FIFO. Presents Instr plus its PC and PC+8 to decode with valid/ready.
//  A taken branch (PCSrc) flushes the buffer and redirects fetch.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (word aligned)
//  DEPTH     2              instruction buffer entries (2..4)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  imem_req     out  1   read request; held until imem_ack
//  imem_addr    out  32  word address of request; stable while imem_req=1
//  imem_ack     in   1   read done; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  Instr        out  32  head-of-buffer instruction to decode
//  PC           out  32  address of Instr
//  PCPlus8      out  32  PC+8 (read value of r15 for Instr)
//  instr_valid  out  1   Instr/PC/PCPlus8 valid
//  instr_ready  in   1   consumer accepts head this cycle
//  PCSrc        in   1   redirect: branch/PC write taken
//  BranchTarget in   32  redirect address; bits[1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (reset=0, async): imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=0, PC=RESET_PC,
//   buffer count=0, state=FETCH, fetch_pc=RESET_PC. Release: first req on first clk edge after.
//  At most one request outstanding. Request issued (imem_req<=1) when
//   count_next < DEPTH and no request outstanding after this edge; imem_addr=fetch_pc.
//  Memory handshake: transfer on imem_req & imem_ack; ack may arrive in first req cycle
//   (zero wait). On transfer: push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32,
//   32'hFFFF_FFFC wraps to 0); req may stay high next cycle with new addr (back-to-back).
//  Latency: ack in cycle N -> instr_valid=1 in cycle N+1 (no bypass).
//  Output: instr_valid = (count!=0); Instr/PC from head entry; PCPlus8 = PC+8 mod 2^32.
//   Pop on instr_valid & instr_ready. Push+pop same cycle with count=DEPTH allowed (count holds).
//   Outputs stable while instr_valid=1 & instr_ready=0.
//  FSM:
//   FETCH: normal. PCSrc=1 -> buffer cleared (count=0), fetch_pc<=BranchTarget&~3;
//          if request outstanding and no ack this cycle -> DROP (req/addr held unchanged);
//          else stay FETCH, next req to target on following cycle.
//   DROP:  req held with old addr; ack -> data discarded, -> FETCH, req target next cycle.
//          PCSrc again in DROP: fetch_pc updated to newest target, stay DROP.
//  Redirect priority: PCSrc beats push and pop in same cycle; ack data in redirect cycle
//   discarded. instr_valid=0 in cycle after redirect.
//  Full: count=DEPTH -> no new req; outstanding one still completes only if a slot is reserved,
//   i.e. issue rule counts outstanding request as occupying a slot.
//  Reset mid-request: all state cleared, req drops immediately; memory must abandon request.
// TESTING
//  1 reset low 3 cycles, release, ack=1 always, ready=1 -> req addr 0,4,8...; Instr valid from
//    cycle 2, PC 0,4,8, PCPlus8 8,12,16, one instruction per cycle.
//  2 ack after 3 wait cycles -> imem_addr stable 4 cycles; one instr per 4 cycles; no dup/skip.
//  3 ready=0 for 10 cycles, ack=1 -> count reaches DEPTH=2, req=0; ready=1 -> PCs 0,4 then 8.
//  4 PCSrc=1 target 32'h103 while req to 0x10 waiting -> DROP, 0x10 data never valid,
//    then req addr 0x100, first valid PC=0x100.
//  5 PCSrc and ack same cycle, target 0x40 -> acked word dropped, next req 0x40, no stale instr.
//  6 RESET_PC=32'hFFFF_FFF8, ack=1 -> PCs FFFF_FFF8, FFFF_FFFC, 0; PCPlus8 wraps to 4; reset
//    asserted mid-wait -> req=0, instr_valid=0 asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Keeps the fetch PC, reads a variable-latency
// instruction memory over a req/ack handshake and buffers fetched words in a
// small FIFO that feeds decode. A taken branch (PCSrc) flushes the buffer and
// redirects fetch. If a memory read is still in flight when the redirect
// arrives, the stage waits for it in DROP and throws the returned word away.
//
// Handshakes:
//  - Memory side: imem_req is raised with imem_addr and both are held
//    unchanged until the cycle in which imem_ack=1. A word transfers on
//    imem_req & imem_ack, and imem_rdata is sampled in that cycle. The ack may
//    come in the first request cycle. Only one request is ever outstanding.
//  - Decode side: instr_valid=1 means Instr/PC/PCPlus8 hold the head entry.
//    They do not change while instr_valid=1 & instr_ready=0. The head is
//    consumed on instr_valid & instr_ready, unless PCSrc is high in that same
//    cycle, because a redirect overrides both push and pop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        fsm_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // FETCH: normal operation. DROP: waiting for a stale read to come back.
  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;

  logic [31:0]        buf_data [DEPTH];
  logic [31:0]        buf_pc   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  logic               transfer;
  logic               push;
  logic               pop;
  logic [31:0]        redirect_pc;
  logic [31:0]        fetch_pc_inc;
  logic               unused_target_bits;

  // The low two bits of the branch target are ignored, so addresses stay word aligned.
  assign redirect_pc        = {BranchTarget[31:2], 2'b00};
  assign unused_target_bits = ^BranchTarget[1:0];
  assign fetch_pc_inc       = fetch_pc + 32'd4;

  // A read transfers on req & ack. Only FETCH keeps the word, and only when no redirect is taken.
  assign transfer = imem_req & imem_ack;
  assign push     = transfer & (state == FETCH) & ~PCSrc;
  assign pop      = instr_valid & instr_ready & ~PCSrc;

  // Occupancy after this edge. It decides whether a new read may be issued.
  always_comb begin
    count_next = count;
    if (PCSrc) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Fetch control: owns the state, the fetch PC and the registered request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (PCSrc) begin
            fetch_pc <= redirect_pc;
            if (imem_req && !imem_ack) begin
              // The read stays in flight with its old address and its data is discarded later.
              state <= DROP;
            end else begin
              // The buffer is now empty, so the read to the target goes out at once.
              imem_req  <= 1'b1;
              imem_addr <= redirect_pc;
            end
          end else begin
            if (transfer) begin
              fetch_pc <= fetch_pc_inc;
            end
            if (imem_req && !imem_ack) begin
              // The request is still waiting. Hold req and addr.
              imem_req <= 1'b1;
            end else if (count_next < DEPTH_C) begin
              // The outstanding read reserves a slot. It only issues when that slot is free.
              imem_req  <= 1'b1;
              imem_addr <= transfer ? fetch_pc_inc : fetch_pc;
            end else begin
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (PCSrc) begin
            fetch_pc <= redirect_pc;
          end
          if (imem_ack) begin
            // The stale word returns here and is dropped. Fetch restarts at the newest target.
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= PCSrc ? redirect_pc : fetch_pc;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Instruction buffer: a circular FIFO of {pc, word}. A redirect empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= 32'd0;
        buf_pc[i]   <= RESET_PC;
      end
    end else if (PCSrc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]   <= fetch_pc;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
    end
  end

  // Decode-facing view of the head entry. There is no bypass from imem_rdata.
  assign instr_valid = (count != '0);
  assign Instr       = buf_data[rd_ptr];
  assign PC          = buf_pc[rd_ptr];
  assign PCPlus8     = PC + 32'd8;
  assign fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Bench for fetch_unit. A memory responder returns a fixed word for every
// address after a random wait. A consumer drives ready and branch redirects.
// The expected instruction stream is a run of sequential PCs that restarts at
// every redirect target.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        fsm_state;

  // clock / reset
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .PCPlus8(PCPlus8),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: the next PCs decode must see, in order
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] p8_log[$];
  int          n_accept = 0;

  // memory responder state
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_wait = 0;
  int          wait_min = 0;
  int          wait_max = 0;
  bit          chk_flush = 1'b0;
  logic [31:0] held_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver: one clock cycle of memory response, consumer ready and redirect
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clk);
    if (imem_req) begin
      if (!mem_pending) begin
        mem_pending = 1'b1;
        mem_addr    = imem_addr;
        mem_wait    = $urandom_range(wait_max, wait_min);
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pending = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_wait--;
      end
    end else begin
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      mem_pending = 1'b0;
    end
    if (chk_flush) begin
      check("valid_after_redirect", 32'(instr_valid), 32'd0);
      chk_flush = 1'b0;
    end
    instr_ready  = rdy;
    PCSrc        = redir;
    BranchTarget = tgt;
    if (redir) begin
      refill(tgt & ~32'h3);
      chk_flush = 1'b1;
    end else if (instr_valid && rdy) begin
      e = exp_q.pop_front();
      check("pc", PC, e);
      check("instr", Instr, mem_word(e));
      check("pc_plus8", PCPlus8, e + 32'd8);
      acc_log.push_back(PC);
      p8_log.push_back(PCPlus8);
      exp_q.push_back(exp_q[$] + 32'd4);
      n_accept++;
    end
  endtask

  task automatic report;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
  endtask

  initial begin
    refill(32'h0);
    // reset held for 3 cycles
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_state", 32'(fsm_state), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    reset = 1'b1;

    // zero-wait memory, always ready
    wait_min = 0; wait_max = 0;
    acc_log.delete(); p8_log.delete();
    cycle(1'b1, 1'b0, 32'h0);
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_valid_c1", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0);
    check("t1_valid_c2", 32'(instr_valid), 32'd1);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check("t1_count", acc_log.size(), 32'd7);
    if (acc_log.size() >= 3) begin
      check("t1_pc2", acc_log[2], 32'h8);
      check("t1_p8_0", p8_log[0], 32'h8);
      check("t1_p8_2", p8_log[2], 32'h10);
    end

    // three wait cycles per read
    wait_min = 3; wait_max = 3;
    repeat (16) cycle(1'b1, 1'b0, 32'h0);
    n_accept = 0;
    repeat (40) cycle(1'b1, 1'b0, 32'h0);
    check("t2_rate", n_accept, 32'd10);

    // consumer stalls until the buffer fills
    wait_min = 0; wait_max = 0;
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    check("t3_full_req", 32'(imem_req), 32'd0);
    check("t3_full_valid", 32'(instr_valid), 32'd1);
    n_accept = 0;
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check("t3_drain", 32'(n_accept >= 4), 32'd1);

    // redirect in the same cycle as an ack
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    check("t5_ack_same", {30'd0, imem_req, imem_ack}, 32'd3);
    cycle(1'b1, 1'b0, 32'h0);
    check("t5_addr", imem_addr, 32'h40);
    check("t5_state", 32'(fsm_state), 32'd0);
    acc_log.delete(); p8_log.delete();
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    check("t5_first", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h40);

    // redirect while a read to 0x10 is waiting
    cycle(1'b0, 1'b1, 32'h10);
    wait_min = 5; wait_max = 5;
    cycle(1'b0, 1'b0, 32'h0);
    check("t4_pending_addr", imem_addr, 32'h10);
    held_addr = imem_addr;
    cycle(1'b0, 1'b1, 32'h103);
    cycle(1'b1, 1'b0, 32'h0);
    check("t4_drop", 32'(fsm_state), 32'd1);
    check("t4_hold_addr", imem_addr, held_addr);
    check("t4_hold_req", 32'(imem_req), 32'd1);
    wait_min = 0; wait_max = 0;
    acc_log.delete(); p8_log.delete();
    repeat (12) cycle(1'b1, 1'b0, 32'h0);
    check("t4_first", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h100);

    // address wrap at the top of memory
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    acc_log.delete(); p8_log.delete();
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    check("wrap_count", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      check("wrap_pc0", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_pc1", acc_log[1], 32'hFFFF_FFFC);
      check("wrap_pc2", acc_log[2], 32'h0);
      check("wrap_p8_0", p8_log[0], 32'h0);
      check("wrap_p8_1", p8_log[1], 32'h4);
      check("wrap_p8_2", p8_log[2], 32'h8);
    end

    // random traffic
    n_accept = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      bit          rr;
      logic [31:0] tg;
      wait_min = 0;
      wait_max = $urandom_range(3, 0);
      rr = ($urandom_range(39, 0) == 0);
      rd = rr ? 1'b0 : ($urandom_range(3, 0) != 0);
      tg = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0))) : $urandom;
      cycle(rd, rr, tg);
    end
    check("random_progress", 32'(n_accept > 200), 32'd1);

    // reset asserted while a read is waiting
    wait_min = 0; wait_max = 0;
    for (int i = 0; i < 20; i++) begin
      if (!imem_req && instr_valid) break;
      cycle(1'b0, 1'b0, 32'h0);
    end
    check("pre_reset_full", {30'd0, imem_req, instr_valid}, 32'd1);
    wait_min = 8; wait_max = 8;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("pre_reset_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_addr", imem_addr, 32'h0);
    mem_pending = 1'b0;
    chk_flush   = 1'b0;
    refill(32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    wait_min = 0; wait_max = 2;
    acc_log.delete(); p8_log.delete();
    repeat (30) cycle(1'b1, 1'b0, 32'h0);
    check("post_reset_first", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h0);

    report();
    $finish;
  end

  // global time bound
  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete (checks=%0d)", n_checks);
    report();
    $fatal(1, "timeout");
  end

endmodule
